// File: rtl/pulse_meter_if.sv
// pulse_meter_if: trigger/mode inputs and result/strobe outputs of pulse_meter.
// master = driver of trigger/mode; slave = pulse_meter itself.
interface pulse_meter_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) ();

  logic [NCH-1:0]       trigger;
  logic                 mode;
  logic                 reset;
  logic [NCH*WIDTH-1:0] counter_out;
  logic [NCH-1:0]       valid;
  logic [NCH-1:0]       overflow;

  modport master (
    output trigger,
    output mode,
    input  reset,
    input  counter_out,
    input  valid,
    input  overflow
  );

  modport slave (
    input  trigger,
    input  mode,
    output reset,
    output counter_out,
    output valid,
    output overflow
  );

endinterface

// File: rtl/pulse_meter.sv
// pulse_meter: per-channel low-time / period meter plus periodic AFE reset.
// Ports: clk, n_rst (async, active-low), bus (pulse_meter_if.slave):
//   trigger[NCH] in, mode in (0 low-time, 1 period), reset out,
//   counter_out[NCH*WIDTH] out, valid[NCH] out, overflow[NCH] out.
// Option: define PULSE_METER_SYNC_EN for a 2-flop trigger synchronizer.
module pulse_meter #(
  parameter int WIDTH      = 8,
  parameter int NCH        = 2,
  parameter int RST_PERIOD = 250
) (
  input  logic         clk,
  input  logic         n_rst,
  pulse_meter_if.slave bus
);

  localparam int DW = $clog2(RST_PERIOD + 1);

  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [DW-1:0]    DTC  = DW'(RST_PERIOD);

  logic [NCH-1:0] w_trig_s;

`ifdef PULSE_METER_SYNC_EN
  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.trigger;
      r_sync2 <= r_sync1;
    end
  end

  assign w_trig_s = r_sync2;
`else
  assign w_trig_s = bus.trigger;
`endif

  // Registered mode; a change disarms
  // every channel for that cycle.
  logic r_mode;
  logic w_mchg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mode <= 1'b0;
    end else begin
      r_mode <= bus.mode;
    end
  end

  assign w_mchg = (bus.mode != r_mode);

  // Reset-pulse divider.
  logic [DW-1:0] r_div;
  logic          r_rst;
  logic          w_tc;

  assign w_tc = (r_div == DTC);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_div <= '0;
      r_rst <= 1'b0;
    end else begin
      r_rst <= w_tc;
      if (w_tc) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign bus.reset = r_rst;

  for (genvar i = 0; i < NCH; i++) begin : g_ch

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_armed;
    logic             r_sat;
    logic             r_prev;
    logic             r_vld;
    logic             r_ovf;

    logic             w_rise;
    logic             w_fall;
    logic             w_full;
    logic [WIDTH-1:0] w_inc;
    logic             w_per;
    logic             w_arm;
    logic             w_end;

    assign w_rise = w_trig_s[i] & ~r_prev;
    assign w_fall = ~w_trig_s[i] & r_prev;

    assign w_full = (r_cnt == CMAX);
    assign w_inc  = w_full ? r_cnt
                           : r_cnt + 1'b1;

    // Period mode: every rise restarts,
    // and captures if already armed.
    assign w_per = ~w_mchg & r_mode
                 & w_rise;
    // Low-time mode: fall arms,
    // rise while armed captures.
    assign w_arm = ~w_mchg & ~r_mode
                 & w_fall;
    assign w_end = ~w_mchg & ~r_mode
                 & w_rise & r_armed;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_cnt   <= '0;
        r_res   <= '0;
        r_armed <= 1'b0;
        r_sat   <= 1'b0;
        r_prev  <= 1'b0;
        r_vld   <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        r_prev <= w_trig_s[i];
        r_vld  <= 1'b0;
        r_cnt  <= w_inc;
        r_sat  <= r_sat | w_full;
        unique case (1'b1)
          w_mchg: begin
            r_armed <= 1'b0;
          end
          w_per: begin
            if (r_armed) begin
              r_res <= r_cnt;
              r_ovf <= r_sat;
              r_vld <= 1'b1;
            end
            r_cnt   <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_sat   <= 1'b0;
            r_armed <= 1'b1;
          end
          w_arm: begin
            r_cnt   <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_sat   <= 1'b0;
            r_armed <= 1'b1;
          end
          w_end: begin
            r_res   <= r_cnt;
            r_ovf   <= r_sat;
            r_vld   <= 1'b1;
            r_armed <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end

    assign bus.counter_out[i*WIDTH +: WIDTH] = r_res;
    assign bus.valid[i]    = r_vld;
    assign bus.overflow[i] = r_ovf;

  end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: measurement counter and result width per channel.
REQ-002 SHALL have parameter NCH, default 2: number of independent trigger channels.
REQ-003 SHALL have parameter RST_PERIOD, default 250: reset-pulse divider terminal count.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port n_rst  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port trigger  input  NCH: asynchronous comparator outputs, bit i drives channel i.
REQ-007 SHALL have port mode  input  1: measurement mode, 0 = low-time, 1 = period.
REQ-008 SHALL have port reset  output  1: periodic one-cycle reset pulse to the analog front end.
REQ-009 SHALL have port counter_out  output  NCH*WIDTH: last captured result, channel i in bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port valid  output  NCH: one-cycle strobe per channel, high in the cycle after counter_out updates.
REQ-011 SHALL have port overflow  output  NCH: per-channel flag, high when the last capture saturated.

Function
REQ-012 SHALL derive per-channel trig_s (per REQ-030/031) and a registered trig_prev; rise = trig_s & !trig_prev, fall = !trig_s & trig_prev.
REQ-013 SHALL keep per channel a WIDTH-bit counter, an armed bit and a sat bit.
REQ-014 SHALL define start edge = fall when mode=0, rise when mode=1; stop edge = rise in both modes.
REQ-015 SHALL, in mode 0 on start edge: counter <= 1, armed <= 1, sat <= 0.
REQ-016 SHALL, in mode 0 on stop edge with armed=1: counter_out[i] <= counter, overflow[i] <= sat, valid[i] <= 1 next cycle, armed <= 0.
REQ-017 SHALL, in mode 1 on rise with armed=1: capture as REQ-016, then counter <= 1, sat <= 0, armed stays 1 (back-to-back periods, no dead cycle).
REQ-018 SHALL, in mode 1 on rise with armed=0: counter <= 1, armed <= 1, no capture.
REQ-019 SHALL otherwise increment counter by 1 each cycle, saturating at 2^WIDTH-1 and setting sat=1 when held there; no wrap-around.
REQ-020 SHALL ignore stop edges while armed=0 (no capture, no valid).
REQ-021 Captured value SHALL equal the number of clk cycles trig_s was low (mode 0) or between consecutive sampled rises (mode 1).
REQ-022 SHALL register mode; any change of the registered mode SHALL clear armed on all channels in that cycle, and no capture occurs that cycle.
REQ-023 Channels SHALL be fully independent; simultaneous edges on several channels SHALL all be captured in the same cycle.
REQ-024 SHALL keep a divider, width ceil(log2(RST_PERIOD+1)), incrementing each cycle; at divider==RST_PERIOD it SHALL wrap to 0 and assert reset for exactly that following cycle.
REQ-025 reset SHALL be high one cycle in every RST_PERIOD+1 cycles, first high after the (RST_PERIOD+1)-th rising clk edge following n_rst release.

Reset
REQ-026 n_rst low SHALL immediately force: reset=0, counter_out=0, valid=0, overflow=0, divider=0, all counters=0, armed=0, sat=0, trig_prev=0, synchronizer flops=0, registered mode=0.
REQ-027 Reset asserted mid-measurement SHALL discard the measurement; no valid after release until a new start edge.
REQ-028 A trigger held high through n_rst release SHALL produce a rise on the first sampled cycle, handled per REQ-018/020 (no capture).

Configuration
REQ-029 Macro PULSE_METER_SYNC_EN SHALL select the input synchronizer.
REQ-030 With PULSE_METER_SYNC_EN defined: trig_s is trigger after a two-flop synchronizer per channel; edge-to-capture latency 3 cycles.
REQ-031 Without it: trig_s = trigger sampled directly; edge-to-capture latency 1 cycle; measured values identical in both builds.

Verification
REQ-032 Mode 0, ch0 trigger low 20 cycles then high -> counter_out[7:0]=20, valid[0] one cycle, overflow[0]=0.
REQ-033 Mode 1, ch1 rises every 37 cycles for 4 periods -> first rise no valid, then three captures of 37, each one-cycle valid.
REQ-034 Mode 0, trigger low 300 cycles, WIDTH=8 -> counter_out=255, overflow=1; next 10-cycle low -> 10, overflow=0.
REQ-035 Free-running clk 1000 cycles after release -> reset high exactly at cycles 251, 502, 753, each one cycle wide.
REQ-036 n_rst pulsed low at cycle 10 of a 20-cycle low phase -> all outputs 0 immediately, no valid at following rise.
REQ-037 mode toggled mid low phase, then rise -> no capture; both channels rise simultaneously after re-arm -> both valid same cycle.
